// File: rtl/enc_telemetry_sched.sv
// enc_telemetry_sched: snapshots all encoder channels on each report tick and streams them as one XOR-checksummed byte frame
module enc_telemetry_sched #(
  parameter int SYSCLK_FREQ    = 100_000_000,
  parameter int REPORT_HZ      = 50,
  parameter int NUM_ENC        = 4,
  parameter int ENC_COUNT_SIZE = 13,
  parameter int TICK_DIV       = SYSCLK_FREQ / REPORT_HZ
) (
  input  logic                              sclk,
  input  logic                              rstn,
  input  logic                              enable,
  input  logic [NUM_ENC*ENC_COUNT_SIZE-1:0] encCount,
  input  logic [NUM_ENC*16-1:0]             pcSpeed,
  input  logic [NUM_ENC*16-1:0]             ptSpeed,
  input  logic                              uartReady,
  output logic                              dataReady,
  output logic [7:0]                        outByte,
  output logic                              frameActive,
  output logic [7:0]                        dropCount
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TOP = CW'(TICK_DIV - 1);
  localparam logic [3:0] LAST = 4'(NUM_ENC - 1);
  typedef enum logic [2:0] {IDLE, HDR, CHID, DATA, CSUM} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0] chan;
  logic [2:0] idx;
  logic [7:0] csum;
  logic [NUM_ENC*48-1:0] snap;
  logic [47:0] cur;
  logic [7:0] data_byte;
  logic tick, xfer, accept;
  // a tick coinciding with the CSUM transfer starts the next frame instead of being dropped
  always_comb begin
    tick = cnt == TOP && enable;
    xfer = dataReady && uartReady;
    accept = tick && (state == IDLE || (state == CSUM && xfer));
    cur = '0;
    for (int i = 0; i < NUM_ENC; i++) if (chan == 4'(i)) cur = snap[i*48 +: 48];
    data_byte = '0;
    for (int j = 0; j < 6; j++) if (idx == 3'(j)) data_byte = cur[(5-j)*8 +: 8];
    dataReady = state != IDLE;
    frameActive = state != IDLE;
    outByte = state == HDR  ? 8'hA5 :
              state == CHID ? {4'h0, chan} :
              state == DATA ? data_byte :
              state == CSUM ? csum : 8'h00;
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? HDR : IDLE;
      HDR:     state_n = xfer ? CHID : HDR;
      CHID:    state_n = xfer ? DATA : CHID;
      DATA:    state_n = xfer && idx == 3'd5 ? (chan == LAST ? CSUM : CHID) : DATA;
      CSUM:    state_n = xfer ? (accept ? HDR : IDLE) : CSUM;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
      chan <= '0;
      idx <= '0;
      csum <= '0;
      dropCount <= '0;
    end else begin
      state <= state_n;
      cnt <= !enable || cnt == TOP ? '0 : cnt + 1'b1;
      if (tick && !accept && dropCount != 8'hFF) dropCount <= dropCount + 8'd1;
      if (accept) begin
        chan <= '0;
        idx <= '0;
        csum <= '0;
        for (int i = 0; i < NUM_ENC; i++)
          snap[i*48 +: 48] <= {16'(encCount[i*ENC_COUNT_SIZE +: ENC_COUNT_SIZE]), pcSpeed[i*16 +: 16], ptSpeed[i*16 +: 16]};
      end else if (xfer) begin
        csum <= csum ^ outByte;
        if (state == CHID) idx <= '0;
        if (state == DATA) begin
          idx <= idx + 3'd1;
          if (idx == 3'd5) chan <= chan + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_enc_telemetry_sched.sv
// tb_enc_telemetry_sched: scoreboard bench for the telemetry frame scheduler
module tb_enc_telemetry_sched;
  localparam int TD = 100, TDS = 20, N = 4, CS = 13;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rstn = 0, enable = 0, uart_ready = 1;
  logic rstn_s = 0, enable_s = 0, ready_s = 0;
  logic [N*CS-1:0] enc;
  logic [N*16-1:0] pc, pt;
  logic data_ready, frame_active, data_ready_s, frame_active_s;
  logic [7:0] out_byte, drop_count, out_byte_s, drop_count_s;
  enc_telemetry_sched #(.NUM_ENC(N), .ENC_COUNT_SIZE(CS), .TICK_DIV(TD)) dut (
    .sclk(clk), .rstn(rstn), .enable(enable), .encCount(enc), .pcSpeed(pc), .ptSpeed(pt),
    .uartReady(uart_ready), .dataReady(data_ready), .outByte(out_byte),
    .frameActive(frame_active), .dropCount(drop_count));
  enc_telemetry_sched #(.NUM_ENC(N), .ENC_COUNT_SIZE(CS), .TICK_DIV(TDS)) dut_s (
    .sclk(clk), .rstn(rstn_s), .enable(enable_s), .encCount(enc), .pcSpeed(pc), .ptSpeed(pt),
    .uartReady(ready_s), .dataReady(data_ready_s), .outByte(out_byte_s),
    .frameActive(frame_active_s), .dropCount(drop_count_s));
  int tests = 0, fails = 0, xfers = 0;
  logic [7:0] last_byte;
  logic [7:0] q[$];
  logic pr_dr = 0, pr_ur = 0;
  logic [7:0] pr_ob = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  function automatic void push_frame();
    logic [7:0] x;
    logic [15:0] c;
    logic [7:0] b [7];
    x = 8'hA5;
    q.push_back(8'hA5);
    for (int i = 0; i < N; i++) begin
      c = 16'(enc[i*CS +: CS]);
      b = '{{4'h0, 4'(i)}, c[15:8], c[7:0], pc[i*16+8 +: 8], pc[i*16 +: 8], pt[i*16+8 +: 8], pt[i*16 +: 8]};
      foreach (b[k]) begin
        q.push_back(b[k]);
        x = x ^ b[k];
      end
    end
    q.push_back(x);
  endfunction
  always @(negedge clk) begin
    if (rstn && pr_dr && !pr_ur) begin
      chk("hold_valid", 32'(data_ready), 1);
      chk("hold_byte", 32'(out_byte), 32'(pr_ob));
    end
    if (rstn && data_ready && uart_ready) begin
      xfers++;
      last_byte = out_byte;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_byte got=%0h exp=none", out_byte);
      end else chk("frame_byte", 32'(out_byte), 32'(q.pop_front()));
    end
    pr_dr = data_ready && rstn;
    pr_ur = uart_ready;
    pr_ob = out_byte;
  end
  task automatic issue(input bit keep);
    push_frame();
    enable = 1;
    repeat (TD - 1) @(posedge clk);
    #1 chk("pre_tick_idle", 32'(data_ready), 0);
    @(posedge clk);
    #1 chk("latency_valid", 32'(data_ready), 1);
    chk("latency_hdr", 32'(out_byte), 32'hA5);
    chk("frame_active", 32'(frame_active), 1);
    if (!keep) enable = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300 && frame_active; i++) begin
      @(posedge clk);
      #1;
    end
    chk("frame_timeout", 32'(frame_active), 0);
  endtask
  task automatic wait_xfers(input int n);
    for (int i = 0; i < 300 && xfers < n; i++) begin
      @(posedge clk);
      #1;
    end
    chk("xfer_timeout", 32'(xfers), 32'(n));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int base, bad, e;
    logic [7:0] prev;
    enc = '0;
    pc = '0;
    pt = '0;
    enc[0 +: CS] = 13'h0ABC;
    pc[0 +: 16] = 16'hFFE0;
    pt[0 +: 16] = 16'h0020;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(data_ready), 0);
    chk("rst_byte", 32'(out_byte), 0);
    chk("rst_active", 32'(frame_active), 0);
    chk("rst_drop", 32'(drop_count), 0);
    rstn = 1;
    base = xfers;
    issue(0);
    wait_idle();
    chk("frame_len1", 32'(xfers - base), 30);
    chk("csum1", 32'(last_byte), 32'h2C);
    base = xfers;
    issue(0);
    for (int i = 0; i < 40 && out_byte !== 8'hBC; i++) begin
      @(posedge clk);
      #1;
    end
    chk("stall_at_bc", 32'(out_byte), 32'hBC);
    uart_ready = 0;
    repeat (5) begin
      @(posedge clk);
      #1 chk("stall_valid", 32'(data_ready), 1);
      chk("stall_byte", 32'(out_byte), 32'hBC);
    end
    uart_ready = 1;
    wait_idle();
    chk("frame_len2", 32'(xfers - base), 30);
    base = xfers;
    issue(0);
    wait_xfers(base + 5);
    enc[0 +: CS] = 13'h0123;
    wait_idle();
    issue(0);
    wait_idle();
    chk("frame_len3", 32'(xfers - base), 60);
    base = xfers;
    issue(1);
    wait_xfers(base + 10);
    enable = 0;
    wait_idle();
    chk("frame_len5", 32'(xfers - base), 30);
    bad = 0;
    repeat (250) begin
      @(posedge clk);
      #1;
      if (data_ready !== 1'b0 || dut.cnt !== '0) bad++;
    end
    chk("disabled_quiet", 32'(bad), 0);
    chk("tick_cnt_zero", 32'(dut.cnt), 0);
    chk("drop_static", 32'(drop_count), 0);
    base = xfers;
    issue(0);
    wait_xfers(base + 15);
    rstn = 0;
    uart_ready = 0;
    @(posedge clk);
    #1;
    rstn = 1;
    uart_ready = 1;
    chk("abort_valid", 32'(data_ready), 0);
    chk("abort_active", 32'(frame_active), 0);
    chk("abort_drop", 32'(drop_count), 0);
    chk("abort_byte", 32'(out_byte), 0);
    chk("abort_left", 32'(q.size()), 15);
    q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("abort_quiet", 32'(data_ready), 0);
    issue(0);
    wait_idle();
    chk("queue_empty", 32'(q.size()), 0);
    rstn_s = 1;
    @(posedge clk);
    #1;
    chk("sat_start", 32'(drop_count_s), 0);
    enable_s = 1;
    e = 0;
    prev = 0;
    for (int c = 0; c < 8000; c++) begin
      ready_s = c % 8 == 7;
      @(posedge clk);
      #1;
      e++;
      if (drop_count_s !== prev) begin
        chk("drop_step", 32'(drop_count_s), 32'(int'(prev) + 1));
        chk("drop_on_tick", 32'(e % TDS), 0);
        prev = drop_count_s;
      end
    end
    chk("drop_sat", 32'(drop_count_s), 255);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
